// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle controller: opcodes, functs, state encodings, ALU codes.
// The BNEBR state exists only when MULTICYCLE_CTRL_BNE_EN is defined.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
`ifdef MULTICYCLE_CTRL_BNE_EN
        ,
        S_BNEBR    = 4'd12
`endif
    } state_t;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU control decode: ALUOp selects add/sub directly, or defers to the R-type funct field.
module alu_decoder
    import multicycle_ctrl_pkg::*;
#(
    parameter int FUNCT_WIDTH = 6
) (
    input  aluop_t                 ALUOp,
    input  logic [FUNCT_WIDTH-1:0] Funct,
    output logic [2:0]             ALUControl
);

    always_comb begin
        ALUControl = ALUC_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALUC_ADD;
            ALUOP_SUB: ALUControl = ALUC_SUB;
            ALUOP_FUNCT: begin
                // Unrecognised functs fall back to add so the datapath stays benign.
                case (Funct)
                    FUNCT_WIDTH'(FUNCT_ADD): ALUControl = ALUC_ADD;
                    FUNCT_WIDTH'(FUNCT_SUB): ALUControl = ALUC_SUB;
                    FUNCT_WIDTH'(FUNCT_AND): ALUControl = ALUC_AND;
                    FUNCT_WIDTH'(FUNCT_OR):  ALUControl = ALUC_OR;
                    FUNCT_WIDTH'(FUNCT_SLT): ALUControl = ALUC_SLT;
                    default:                 ALUControl = ALUC_ADD;
                endcase
            end
            default: ALUControl = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style multicycle MIPS controller; rst forces FETCH and blanks every output while high.
// Optional bne support is enabled by defining MULTICYCLE_CTRL_BNE_EN.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OP_WIDTH    = 6,
    parameter int FUNCT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OP_WIDTH-1:0]    Op,
    input  logic [FUNCT_WIDTH-1:0] Funct,
    input  logic                   Zero,
    output logic                   IorD,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   PCEn,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSrc,
    output logic [2:0]             ALUControl,
    output logic [3:0]             State
);

    state_t     state_reg, state_next;
    aluop_t     alu_op;
    logic       iord_dec, mem_write_dec, ir_write_dec, pc_write, branch;
    logic       reg_dst_dec, memto_reg_dec, reg_write_dec, alu_src_a_dec;
    logic [1:0] alu_src_b_dec, pc_src_dec;
    logic       branch_cond;
    logic [2:0] alu_control_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = S_FETCH;
        alu_op        = ALUOP_ADD;
        iord_dec      = 1'b0;
        mem_write_dec = 1'b0;
        ir_write_dec  = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        reg_dst_dec   = 1'b0;
        memto_reg_dec = 1'b0;
        reg_write_dec = 1'b0;
        alu_src_a_dec = 1'b0;
        alu_src_b_dec = 2'b00;
        pc_src_dec    = 2'b00;
        branch_cond   = Zero;
        case (state_reg)
            S_FETCH: begin
                state_next    = S_DECODE;
                ir_write_dec  = 1'b1;
                pc_write      = 1'b1;
                alu_src_b_dec = 2'b01;
            end
            S_DECODE: begin
                alu_src_b_dec = 2'b11;
                if (Op == OP_WIDTH'(OP_LW) || Op == OP_WIDTH'(OP_SW)) state_next = S_MEMADR;
                else if (Op == OP_WIDTH'(OP_RTYPE))                   state_next = S_EXECUTE;
                else if (Op == OP_WIDTH'(OP_BEQ))                     state_next = S_BRANCH;
                else if (Op == OP_WIDTH'(OP_ADDI))                    state_next = S_ADDIEXEC;
                else if (Op == OP_WIDTH'(OP_J))                       state_next = S_JUMP;
`ifdef MULTICYCLE_CTRL_BNE_EN
                else if (Op == OP_WIDTH'(OP_BNE))                     state_next = S_BNEBR;
`endif
                else                                                  state_next = S_FETCH;
            end
            S_MEMADR: begin
                state_next    = (Op == OP_WIDTH'(OP_LW)) ? S_MEMREAD : S_MEMWRITE;
                alu_src_a_dec = 1'b1;
                alu_src_b_dec = 2'b10;
            end
            S_MEMREAD: begin
                state_next = S_MEMWB;
                iord_dec   = 1'b1;
            end
            S_MEMWB: begin
                memto_reg_dec = 1'b1;
                reg_write_dec = 1'b1;
            end
            S_MEMWRITE: begin
                iord_dec      = 1'b1;
                mem_write_dec = 1'b1;
            end
            S_EXECUTE: begin
                state_next    = S_ALUWB;
                alu_src_a_dec = 1'b1;
                alu_op        = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst_dec   = 1'b1;
                reg_write_dec = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_dec = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_src_dec    = 2'b01;
                branch        = 1'b1;
            end
            S_ADDIEXEC: begin
                state_next    = S_ADDIWB;
                alu_src_a_dec = 1'b1;
                alu_src_b_dec = 2'b10;
            end
            S_ADDIWB: reg_write_dec = 1'b1;
            S_JUMP: begin
                pc_src_dec = 2'b10;
                pc_write   = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_BNE_EN
            S_BNEBR: begin
                alu_src_a_dec = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_src_dec    = 2'b01;
                branch        = 1'b1;
                branch_cond   = ~Zero;
            end
`endif
            default: state_next = S_FETCH;
        endcase
    end

    alu_decoder #(
        .FUNCT_WIDTH(FUNCT_WIDTH)
    ) u_alu_decoder (
        .ALUOp     (alu_op),
        .Funct     (Funct),
        .ALUControl(alu_control_dec)
    );

    // Reset blanks the decoded FETCH strobes combinationally, not just the state register.
    assign IorD       = iord_dec      & ~rst;
    assign MemWrite   = mem_write_dec & ~rst;
    assign IRWrite    = ir_write_dec  & ~rst;
    assign PCEn       = (pc_write | (branch & branch_cond)) & ~rst;
    assign RegDst     = reg_dst_dec   & ~rst;
    assign MemtoReg   = memto_reg_dec & ~rst;
    assign RegWrite   = reg_write_dec & ~rst;
    assign ALUSrcA    = alu_src_a_dec & ~rst;
    assign ALUSrcB    = rst ? 2'b00  : alu_src_b_dec;
    assign PCSrc      = rst ? 2'b00  : pc_src_dec;
    assign ALUControl = rst ? 3'b000 : alu_control_dec;
    assign State      = rst ? 4'd0   : 4'(state_reg);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an instruction-level reference model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic [18:0] obs;

    int total = 0;
    int bad   = 0;

`ifdef MULTICYCLE_CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.OP_WIDTH(6), .FUNCT_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .State(State)
    );

    assign obs = {State, IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite,
                  ALUSrcA, ALUSrcB, PCSrc, ALUControl};

    function automatic logic [2:0] alu_ref(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic int latency(input logic [5:0] op);
        case (op)
            6'b100011:                       return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010:            return 3;
            6'b000101:                       return BNE_EN ? 3 : 2;
            default:                         return 2;
        endcase
    endfunction

    function automatic int writes(input logic [5:0] op);
        return (op == 6'b100011 || op == 6'b000000 || op == 6'b001000) ? 1 : 0;
    endfunction

    // Expected output bundle for cycle k of an instruction (k=0 is its FETCH cycle).
    function automatic logic [18:0] exp_vec(input logic [5:0] op, input logic [5:0] f,
                                            input logic z, input int k);
        logic [3:0] st;
        logic iord, mw, irw, pcen, rd, m2r, rw, asa;
        logic [1:0] asb, pcs;
        logic [2:0] ac;
        st = 4'd0; iord = 0; mw = 0; irw = 0; pcen = 0; rd = 0; m2r = 0; rw = 0; asa = 0;
        asb = 2'b00; pcs = 2'b00; ac = 3'b010;
        if (k == 0) begin
            st = 4'd0; irw = 1; pcen = 1; asb = 2'b01;
        end else if (k == 1) begin
            st = 4'd1; asb = 2'b11;
        end else begin
            case (op)
                6'b100011, 6'b101011: begin
                    if (k == 2) begin st = 4'd2; asa = 1; asb = 2'b10; end
                    else if (op == 6'b101011) begin st = 4'd5; iord = 1; mw = 1; end
                    else if (k == 3) begin st = 4'd3; iord = 1; end
                    else begin st = 4'd4; m2r = 1; rw = 1; end
                end
                6'b000000: begin
                    if (k == 2) begin st = 4'd6; asa = 1; ac = alu_ref(f); end
                    else begin st = 4'd7; rd = 1; rw = 1; end
                end
                6'b001000: begin
                    if (k == 2) begin st = 4'd9; asa = 1; asb = 2'b10; end
                    else begin st = 4'd10; rw = 1; end
                end
                6'b000100: begin st = 4'd8;  asa = 1; ac = 3'b110; pcs = 2'b01; pcen = z; end
                6'b000101: begin st = 4'd12; asa = 1; ac = 3'b110; pcs = 2'b01; pcen = ~z; end
                6'b000010: begin st = 4'd11; pcs = 2'b10; pcen = 1; end
                default: st = 4'd0;
            endcase
        end
        return {st, iord, mw, irw, pcen, rd, m2r, rw, asa, asb, pcs, ac};
    endfunction

    // Entered with the DUT in FETCH shortly after a rising edge; leaves it the same way.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] f,
                             input logic z);
        int n;
        int rw_cnt;
        int overlap;
        logic [18:0] want;
        n = latency(op); rw_cnt = 0; overlap = 0;
        Op = op; Funct = f; Zero = z;
        for (int k = 0; k < n; k++) begin
            #1;
            want = exp_vec(op, f, z, k);
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL %s cyc%0d op=%b funct=%b zero=%b got=%h want=%h",
                         name, k, op, f, z, obs, want);
            end
            if (RegWrite === 1'b1) rw_cnt++;
            if (RegWrite === 1'b1 && MemWrite === 1'b1) overlap++;
            @(posedge clk);
        end
        #1;
        total++;
        if (rw_cnt != writes(op) || overlap != 0 || State !== 4'd0) begin
            bad++;
            $display("FAIL %s_end regwrites=%0d overlap=%0d state=%0d want regwrites=%0d overlap=0 state=0",
                     name, rw_cnt, overlap, State, writes(op));
        end
        $display("instr %s op=%b funct=%b zero=%b cycles=%0d regwrites=%0d",
                 name, op, f, z, n, rw_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1; Op = 6'b100011; Funct = 6'b0; Zero = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs !== 19'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", obs, 19'd0);
        end
        rst = 1'b0;
        #1;
        total++;
        if (obs !== exp_vec(6'b0, 6'b0, 1'b0, 0)) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", obs, exp_vec(6'b0, 6'b0, 1'b0, 0));
        end
        $display("reset done state=%0d", State);
    endtask

    task automatic test_reset_midinstr();
        Op = 6'b100011; Funct = 6'b0; Zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (State !== 4'd3) begin
            bad++;
            $display("FAIL midrst_reach state=%0d want=3", State);
        end
        rst = 1'b1;
        #1;
        total++;
        if (obs !== 19'd0) begin
            bad++;
            $display("FAIL midrst_blank got=%h want=%h", obs, 19'd0);
        end
        @(posedge clk);
        #1;
        total++;
        if (State !== 4'd0 || RegWrite !== 1'b0 || PCEn !== 1'b0) begin
            bad++;
            $display("FAIL midrst_next state=%0d regwrite=%b pcen=%b want 0 0 0", State, RegWrite, PCEn);
        end
        rst = 1'b0;
        #1;
        total++;
        if (obs !== exp_vec(6'b0, 6'b0, 1'b0, 0)) begin
            bad++;
            $display("FAIL midrst_fetch got=%h want=%h", obs, exp_vec(6'b0, 6'b0, 1'b0, 0));
        end
        $display("reset mid-lw done state=%0d", State);
    endtask

    task automatic test_directed();
        run_instr("lw",      6'b100011, 6'b000000, 1'b0);
        run_instr("sw",      6'b101011, 6'b000000, 1'b1);
        run_instr("slt",     6'b000000, 6'b101010, 1'b0);
        run_instr("add",     6'b000000, 6'b100000, 1'b0);
        run_instr("sub",     6'b000000, 6'b100010, 1'b1);
        run_instr("and",     6'b000000, 6'b100100, 1'b0);
        run_instr("or",      6'b000000, 6'b100101, 1'b0);
        run_instr("rbad",    6'b000000, 6'b111000, 1'b0);
        run_instr("addi",    6'b001000, 6'b000000, 1'b0);
        run_instr("beq_t",   6'b000100, 6'b000000, 1'b1);
        run_instr("beq_nt",  6'b000100, 6'b000000, 1'b0);
        run_instr("bne_z0",  6'b000101, 6'b000000, 1'b0);
        run_instr("bne_z1",  6'b000101, 6'b000000, 1'b1);
        run_instr("j",       6'b000010, 6'b000000, 1'b0);
        run_instr("illegal", 6'b111111, 6'b000000, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [8];
        logic [5:0] fns [5];
        logic [5:0] op, f;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b000010, 6'b000101, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr("rand", op, f, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_midinstr();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
